// File: rtl/serial_receiver_pkg.sv
// Shared definitions for the one-bit-per-clock serial link (receiver and transmitter sides).
package serial_receiver_pkg;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t StIdle     = 3'd0;
    localparam rx_state_t StData     = 3'd1;
    localparam rx_state_t StParity   = 3'd2;
    localparam rx_state_t StStop     = 3'd3;
    localparam rx_state_t StWaitHigh = 3'd4;

    // Frame length in bit-times: start + data + optional parity + stop.
    function automatic int unsigned frame_len(input int unsigned data_width,
                                              input int unsigned parity_en);
        return data_width + parity_en + 2;
    endfunction

endpackage

// File: rtl/serial_receiver_rx_control_unit.sv
// Receiver control unit: frame FSM, bit counter and the per-frame accept/error verdict.
module serial_receiver_rx_control_unit
    import serial_receiver_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic rx_i,
    output logic shift_en_o,
    output logic accept_o,
    output logic busy_o,
    output logic frame_error_o,
    output logic parity_error_o
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

    rx_state_t       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            par_q, par_d;
    logic            par_bad_q, par_bad_d;
    logic            ferr_q, ferr_d;
    logic            perr_q, perr_d;
    logic            accept;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        par_d     = par_q;
        par_bad_d = par_bad_q;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;
        accept    = 1'b0;
        case (state_q)
            StIdle: begin
                if (!rx_i) begin
                    state_d   = StData;
                    cnt_d     = '0;
                    par_d     = 1'b0;
                    par_bad_d = 1'b0;
                end
            end
            StData: begin
                cnt_d = cnt_q + 1'b1;
                par_d = par_q ^ rx_i;
                if (cnt_q == LastBit) begin
                    state_d = (PARITY_EN != 0) ? StParity : StStop;
                end
            end
            StParity: begin
                par_bad_d = rx_i != (par_q ^ (PARITY_ODD != 0));
                state_d   = StStop;
            end
            StStop: begin
                // A bad stop bit masks any parity verdict for the same frame.
                if (!rx_i) begin
                    ferr_d  = 1'b1;
                    state_d = StWaitHigh;
                end else if (par_bad_q) begin
                    perr_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    accept  = 1'b1;
                    state_d = StIdle;
                end
            end
            StWaitHigh: begin
                if (rx_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            par_q     <= 1'b0;
            par_bad_q <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            par_q     <= par_d;
            par_bad_q <= par_bad_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
        end
    end

    assign shift_en_o     = (state_q == StData);
    assign accept_o       = accept;
    assign busy_o         = (state_q != StIdle);
    assign frame_error_o  = ferr_q;
    assign parity_error_o = perr_q;

endmodule

// File: rtl/serial_receiver.sv
// Serial link receiver: deserializes frames into a hold-until-acknowledged output word.
module serial_receiver
    import serial_receiver_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  rx_i,
    input  logic                  read_ack_i,
    output logic [DATA_WIDTH-1:0] data_out_o,
    output logic                  data_valid_o,
    output logic                  busy_o,
    output logic                  frame_error_o,
    output logic                  parity_error_o,
    output logic                  overrun_o
);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ovr_q, ovr_d;
    logic                  shift_en;
    logic                  accept;
    logic                  load;

    serial_receiver_rx_control_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .PARITY_EN  (PARITY_EN),
        .PARITY_ODD (PARITY_ODD)
    ) u_ctrl (
        .clk_i          (clk_i),
        .arst_i         (arst_i),
        .rx_i           (rx_i),
        .shift_en_o     (shift_en),
        .accept_o       (accept),
        .busy_o         (busy_o),
        .frame_error_o  (frame_error_o),
        .parity_error_o (parity_error_o)
    );

    always_comb begin
        shift_d = shift_q;
        if (shift_en) begin
            shift_d = {rx_i, shift_q[DATA_WIDTH-1:1]};
        end
        // An ack in the accept cycle frees the register for the incoming word.
        load    = accept & (~valid_q | read_ack_i);
        data_d  = load ? shift_q : data_q;
        valid_d = valid_q;
        if (load) begin
            valid_d = 1'b1;
        end else if (read_ack_i) begin
            valid_d = 1'b0;
        end
        ovr_d = read_ack_i ? 1'b0 : (ovr_q | (accept & valid_q));
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out_o   = data_q;
    assign data_valid_o = valid_q;
    assign overrun_o    = ovr_q;

endmodule
